pipeline_stall_sequencer: RTL and testbench
===========================================

# pipeline_stall_sequencer

Sequencing controller for the 5-stage MIPS pipeline. It sits between the per-stage hazard comparators and the pipeline registers, and turns single-cycle hazard indications into multi-cycle stall, bubble and flush sequences. It covers RAW hazards not fully covered by forwarding, load-use, the taken-branch flush, and the multi-cycle multiplier handshake. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_TIMEOUT, default 16: maximum MUL_WAIT cycles before MulTimeout is raised.
- CNT_W, default 16: width of the StallCycles counter.

Ports:
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- LoadUse  in  1  load in ID/EX whose Rt matches IF/ID Rs or Rt.
- RawDist  in  2  non-forwardable RAW distance from the IF/ID reader to the nearest writer. 0 = none, 1 = writer in EX, 2 = writer in MEM, 3 = writer in WB.
- BranchTaken  in  1  branch resolved taken in ID.
- MulReq  in  1  ID/EX holds a mult instruction.
- MulDone  in  1  multiplier result valid (one-cycle pulse).
- PCWrite  out  1  1 = PC updates.
- IF_ID_Write  out  1  1 = IF/ID register loads.
- IF_Flush  out  1  1 = IF/ID loads a NOP.
- ID_EX_Bubble  out  1  1 = ID/EX loads zeros (control NOP).
- ID_EX_Hold  out  1  1 = ID/EX keeps its contents.
- EX_MEM_Bubble  out  1  1 = EX/MEM loads zeros.
- MulGo  out  1  one-cycle start pulse to the multiplier.
- MulTimeout  out  1  sticky error flag, cleared only by Rst.
- StallCycles  out  CNT_W  saturating count of cycles with PCWrite=0.

## Operation
- States: RUN, RAW_WAIT, MUL_WAIT. Internal bubble counter Bcnt is 2 bits.
- Bubbles required: N = max(LoadUse ? 1 : 0, RawDist==1 ? 2 : RawDist==2 ? 1 : 0). RawDist==3 needs 0 bubbles (write-first register file).
- RUN, priority order:
  - MulReq: MulGo=1, ID_EX_Hold=1, PCWrite=0, IF_ID_Write=0, EX_MEM_Bubble=1. Next state is MUL_WAIT.
  - else N>0: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. If N=2, Bcnt<=1 and next state is RAW_WAIT; otherwise stay in RUN.
  - else BranchTaken: IF_Flush=1, PC advances to the target.
  - else: all enables 1, all bubbles, holds and flushes 0.
- BranchTaken is ignored in any cycle where ID is stalled. The branch re-presents once the stall clears.
- RAW_WAIT: same outputs as the RUN N>0 case. All hazard inputs are ignored; the sequence is counter-driven. Bcnt decrements each cycle; when Bcnt==0, next state is RUN.
- MUL_WAIT:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Bubble=1, MulGo=0.
  - On MulDone: ID_EX_Hold=0 and EX_MEM_Bubble=0 in that same cycle (EX/MEM captures the product). Next state is RUN.
  - A wait counter counts MUL_WAIT cycles. Reaching MUL_TIMEOUT sets MulTimeout and forces RUN.
- ID_EX_Hold and ID_EX_Bubble are never both 1.
- StallCycles increments on each cycle with PCWrite=0 and Rst=0. It saturates at 2^CNT_W-1.

## Timing
- Outputs are combinational from state and inputs, so a stall takes effect in the same cycle the hazard is presented.
- Bubble counts: RawDist=1 gives exactly 2 stall cycles. RawDist=2 or LoadUse gives exactly 1.
- MulGo is asserted exactly one cycle per mult. The earliest legal MulDone is the cycle after MulGo. A MulDone seen in RUN is ignored.
- Mult stall length is (cycles from MulGo to MulDone) + 1.
- Reset values, while Rst=1 and in the first cycle after release:
  - during Rst=1: PCWrite=0, IF_ID_Write=0, IF_Flush=0, ID_EX_Bubble=1, ID_EX_Hold=0, EX_MEM_Bubble=1, MulGo=0.
  - after the Rst edge: state=RUN, Bcnt=0, MulTimeout=0, StallCycles=0.
- Rst asserted mid-RAW_WAIT or mid-MUL_WAIT aborts the sequence immediately; no MulGo is reissued.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state encoding (RUN=2'd0, RAW_WAIT=2'd1, MUL_WAIT=2'd2);
  - RawDist constants (RAW_NONE, RAW_EX, RAW_MEM, RAW_WB);
  - bubble-count function.
- One sub-module, sat_counter: parameterised width, with increment enable and synchronous clear. Used for StallCycles and the MUL_WAIT timeout counter.

## Test plan
- RawDist=1 for one cycle, then 2, then 3 (writer advancing) -> PCWrite=0 for exactly 2 cycles, ID_EX_Bubble=1 both cycles, StallCycles=2.
- LoadUse=1 together with BranchTaken=1 -> cycle 0: stall, IF_Flush=0. Cycle 1 (LoadUse=0, BranchTaken held): IF_Flush=1, PCWrite=1.
- MulReq=1 with MulDone 4 cycles after MulGo -> MulGo high 1 cycle, ID_EX_Hold=1 for 4 cycles, EX_MEM_Bubble drops in the MulDone cycle, StallCycles=5.
- MulReq with no MulDone, MUL_TIMEOUT=16 -> MulTimeout=1 after 16 MUL_WAIT cycles, state returns to RUN, flag stays set until Rst.
- Rst pulsed in the 2nd cycle of MUL_WAIT -> next cycle state=RUN, StallCycles=0, MulTimeout=0, no extra MulGo.
- CNT_W=4, 20 consecutive stall cycles -> StallCycles saturates at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline stall sequencer
// Contents: controller state encoding, RawDist codes, bubble-count helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RAW_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  // Distance from the IF/ID reader to the nearest non-forwardable writer.
  localparam logic [1:0] RAW_NONE = 2'd0;
  localparam logic [1:0] RAW_EX   = 2'd1;
  localparam logic [1:0] RAW_MEM  = 2'd2;
  localparam logic [1:0] RAW_WB   = 2'd3;

  // Bubbles needed before the ID-stage instruction may advance.
  // A writer in WB needs none because the register file writes first.
  function automatic logic [1:0] bubble_count(input logic load_use, input logic [1:0] raw_dist);
    logic [1:0] raw_n;
    case (raw_dist)
      RAW_EX:  raw_n = 2'd2;
      RAW_MEM: raw_n = 2'd1;
      default: raw_n = 2'd0;
    endcase
    if (load_use && (raw_n == 2'd0))
      return 2'd1;
    return raw_n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk   in   clock
//   clr   in   synchronous clear (wins over inc)
//   inc   in   count up by one, holding at all-ones
//   count out  current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// rtl/pipeline_stall_sequencer.sv - stall/bubble/flush sequencer for the 5-stage MIPS pipeline
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   LoadUse, RawDist         hazard indications from the ID-stage comparators
//   BranchTaken              branch resolved taken in ID
//   MulReq, MulDone          multiplier request (ID/EX holds mult) and result pulse
//   PCWrite, IF_ID_Write     front-end enables
//   IF_Flush                 IF/ID loads a NOP
//   ID_EX_Bubble/ID_EX_Hold  ID/EX control-NOP / keep contents
//   EX_MEM_Bubble            EX/MEM loads zeros
//   MulGo                    one-cycle multiplier start
//   MulTimeout               sticky multiplier timeout flag
//   StallCycles              saturating count of PCWrite=0 cycles
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             LoadUse,
  input  logic [1:0]       RawDist,
  input  logic             BranchTaken,
  input  logic             MulReq,
  input  logic             MulDone,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_EX_Bubble,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Bubble,
  output logic             MulGo,
  output logic             MulTimeout,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int WAIT_W = $clog2(MUL_TIMEOUT + 1);

  state_t            state;
  logic [1:0]        bcnt;
  logic [1:0]        need;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mul_expire;

  assign need = bubble_count(LoadUse, RawDist);

  // wait_cnt is 0 in the first MUL_WAIT cycle, so the last allowed cycle sees MUL_TIMEOUT-1.
  assign mul_expire = (state == MUL_WAIT) && !MulDone &&
                      (wait_cnt == WAIT_W'(MUL_TIMEOUT - 1));

  // Outputs are combinational so a hazard stalls in the cycle it is presented.
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_Flush      = 1'b0;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MulGo         = 1'b0;
    if (Rst) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (MulReq) begin
            MulGo         = 1'b1;
            ID_EX_Hold    = 1'b1;
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
          end else if (need != 2'd0) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (BranchTaken) begin
            IF_Flush = 1'b1;
          end
        end
        RAW_WAIT: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
        MUL_WAIT: begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          // Release ID/EX and let EX/MEM capture the product in the MulDone cycle.
          ID_EX_Hold    = !MulDone;
          EX_MEM_Bubble = !MulDone;
        end
        default: begin
          PCWrite       = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Bubble  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= RUN;
      bcnt       <= 2'd0;
      MulTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MulReq) begin
            state <= MUL_WAIT;
          end else if (need == 2'd2) begin
            bcnt  <= 2'd1;
            state <= RAW_WAIT;
          end
        end
        RAW_WAIT: begin
          // Leave once the decrement brings Bcnt to zero, so RUN + RAW_WAIT
          // together give exactly the requested bubble count.
          if (bcnt != 2'd0)
            bcnt <= bcnt - 2'd1;
          if (bcnt <= 2'd1)
            state <= RUN;
        end
        MUL_WAIT: begin
          if (MulDone) begin
            state <= RUN;
          end else if (mul_expire) begin
            MulTimeout <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .clr   (Rst),
    .inc   (!PCWrite),
    .count (StallCycles)
  );

  // Cleared outside MUL_WAIT so every multiply starts its wait from zero.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (Clk),
    .clr   (Rst || (state != MUL_WAIT)),
    .inc   (state == MUL_WAIT),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb/tb_pipeline_stall_sequencer.sv - scoreboard bench for pipeline_stall_sequencer
module tb_pipeline_stall_sequencer;

  localparam int MT = 16;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst = 1'b1;
  logic       LoadUse = 1'b0;
  logic [1:0] RawDist = 2'd0;
  logic       BranchTaken = 1'b0;
  logic       MulReq = 1'b0;
  logic       MulDone = 1'b0;

  logic        a_pcw, a_ifw, a_flush, a_bub, a_hold, a_exb, a_go, a_tmo;
  logic [15:0] a_cnt;
  logic        b_pcw, b_ifw, b_flush, b_bub, b_hold, b_exb, b_go, b_tmo;
  logic [3:0]  b_cnt;

  pipeline_stall_sequencer #(.MUL_TIMEOUT(MT), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .LoadUse(LoadUse), .RawDist(RawDist),
    .BranchTaken(BranchTaken), .MulReq(MulReq), .MulDone(MulDone),
    .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_Flush(a_flush),
    .ID_EX_Bubble(a_bub), .ID_EX_Hold(a_hold), .EX_MEM_Bubble(a_exb),
    .MulGo(a_go), .MulTimeout(a_tmo), .StallCycles(a_cnt)
  );

  pipeline_stall_sequencer #(.MUL_TIMEOUT(MT), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .LoadUse(LoadUse), .RawDist(RawDist),
    .BranchTaken(BranchTaken), .MulReq(MulReq), .MulDone(MulDone),
    .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_Flush(b_flush),
    .ID_EX_Bubble(b_bub), .ID_EX_Hold(b_hold), .EX_MEM_Bubble(b_exb),
    .MulGo(b_go), .MulTimeout(b_tmo), .StallCycles(b_cnt)
  );

  typedef struct packed {
    logic [6:0]  outs;   // {PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, MulGo}
    logic        known;  // counter/flag state defined (a reset has been seen)
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  // Reference model: remaining forced stalls, multiply wait length, sticky flag, raw stall total.
  int raw_left = 0;
  int mul_n    = 0;
  bit in_mul   = 0;
  bit m_tmo    = 0;
  bit known    = 0;
  int cnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input bit r, input bit lu, input logic [1:0] rd,
                      input bit bt, input bit mr, input bit md);
    exp_t e;
    bit pcw, ifw, flush, bub, hold, exb, go;
    int n;
    @(posedge Clk);
    #1;
    Rst = r; LoadUse = lu; RawDist = rd; BranchTaken = bt; MulReq = mr; MulDone = md;
    pcw = 1; ifw = 1; flush = 0; bub = 0; hold = 0; exb = 0; go = 0;
    e.known = known;
    e.tmo   = m_tmo;
    e.cnt   = cnt;
    if (r) begin
      pcw = 0; ifw = 0; bub = 1; exb = 1;
      raw_left = 0; in_mul = 0; m_tmo = 0; cnt = 0; known = 1;
    end else if (raw_left > 0) begin
      pcw = 0; ifw = 0; bub = 1;
      raw_left--;
    end else if (in_mul) begin
      pcw = 0; ifw = 0;
      mul_n++;
      if (md) begin
        in_mul = 0;
      end else begin
        hold = 1; exb = 1;
        if (mul_n == MT) begin
          in_mul = 0;
          m_tmo  = 1;
        end
      end
    end else if (mr) begin
      go = 1; hold = 1; pcw = 0; ifw = 0; exb = 1;
      in_mul = 1; mul_n = 0;
    end else begin
      n = lu ? 1 : 0;
      if (rd == 2'd1) n = 2;
      else if (rd == 2'd2 && n < 1) n = 1;
      if (n > 0) begin
        pcw = 0; ifw = 0; bub = 1;
        raw_left = n - 1;
      end else if (bt) begin
        flush = 1;
      end
    end
    if (!r && !pcw) cnt++;
    e.outs = {pcw, ifw, flush, bub, hold, exb, go};
    sb.push_back(e);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    logic [31:0] e16, e4;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("outs_a", {25'd0, a_pcw, a_ifw, a_flush, a_bub, a_hold, a_exb, a_go}, {25'd0, e.outs});
      chk("outs_b", {25'd0, b_pcw, b_ifw, b_flush, b_bub, b_hold, b_exb, b_go}, {25'd0, e.outs});
      chk("hold_and_bubble", {31'd0, a_hold & a_bub}, 32'd0);
      if (e.known) begin
        e16 = (e.cnt > 32'd65535) ? 32'd65535 : e.cnt;
        e4  = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
        chk("timeout_a", {31'd0, a_tmo}, {31'd0, e.tmo});
        chk("timeout_b", {31'd0, b_tmo}, {31'd0, e.tmo});
        chk("stall_cnt16", {16'd0, a_cnt}, e16);
        chk("stall_cnt4", {28'd0, b_cnt}, e4);
      end
    end
  end

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // RAW writer advancing EX -> MEM -> WB
    step(0, 0, 2'd1, 0, 0, 0);
    step(0, 0, 2'd2, 0, 0, 0);
    step(0, 0, 2'd3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // load-use masks a taken branch, branch re-presents
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // multiply with MulDone four cycles after MulGo
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // multiply timeout, flag sticky until reset
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 22; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset during the second MUL_WAIT cycle
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 20 consecutive stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
